// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared types and constants for the board LED / DIP serial chains.
// Revision : 1.0
// ============================================================================
package led_pkg;

  localparam int LED_FRAME_WIDTH = 21;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } led_state_e;

endpackage : led_pkg
`default_nettype wire

// File: rtl/shift_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : shift_tick_gen
// Brief    : One-cycle tick every CLK_DIV cycles while enabled; restarts on clear.
// Revision : 1.0
// ============================================================================
module shift_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                 c_div_w = $clog2(CLK_DIV) + 1;
  localparam logic [c_div_w-1:0] c_last  = c_div_w'(CLK_DIV - 1);

  logic [c_div_w-1:0] divcnt_q;
  logic [c_div_w-1:0] divcnt_d;

  assign o_tick = i_en && (divcnt_q == c_last);

  always_comb begin
    divcnt_d = divcnt_q;
    if (i_clr || !i_en || o_tick) begin
      divcnt_d = '0;
    end else begin
      divcnt_d = divcnt_q + c_div_w'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      divcnt_q <= '0;
    end else begin
      divcnt_q <= divcnt_d;
    end
  end

endmodule : shift_tick_gen
`default_nettype wire

// File: rtl/led_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_shift_driver
// Brief    : Serialises {aux, data} MSB-first into a 74HC595-style chain, then
//            pulses the storage latch. All outputs are registered.
// Revision : 1.0
// ============================================================================
module led_shift_driver
  import led_pkg::*;
#(
  parameter int WIDTH   = LED_FRAME_WIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic [4:0]  i_aux,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_LEDData,
  output logic        o_LEDClk,
  output logic        o_LEDLatch
);

  localparam int                 c_bit_w    = $clog2(WIDTH);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WIDTH - 1);

  led_state_e         state_q, state_d;
  logic [WIDTH-1:0]   frame_q, frame_d;
  logic [c_bit_w-1:0] bitcnt_q, bitcnt_d;
  logic               led_data_q, led_data_d;
  logic               led_clk_q, led_clk_d;
  logic               led_latch_q, led_latch_d;
  logic               ready_q, ready_d;
  logic               w_tick;
  logic               w_handshake;

  assign w_handshake = i_valid && (state_q == IDLE);

  shift_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q != IDLE),
    .i_clr  (w_handshake),
    .o_tick (w_tick)
  );

  // The frame register shifts left so its MSB is always the bit on the wire.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bitcnt_d   = bitcnt_q;
    led_data_d = led_data_q;
    case (state_q)
      IDLE: begin
        if (w_handshake) begin
          state_d    = SHIFT_LO;
          frame_d    = WIDTH'({i_aux, i_data});
          bitcnt_d   = '0;
          led_data_d = frame_d[WIDTH-1];
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          if (bitcnt_q == c_last_bit) begin
            state_d = LATCH;
          end else begin
            state_d    = SHIFT_LO;
            bitcnt_d   = bitcnt_q + c_bit_w'(1);
            frame_d    = {frame_q[WIDTH-2:0], 1'b0};
            led_data_d = frame_d[WIDTH-1];
          end
        end
      end
      LATCH: begin
        if (w_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    led_clk_d   = (state_d == SHIFT_HI);
    led_latch_d = (state_d == LATCH);
    ready_d     = (state_d == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      bitcnt_q    <= '0;
      led_data_q  <= 1'b0;
      led_clk_q   <= 1'b0;
      led_latch_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bitcnt_q    <= bitcnt_d;
      led_data_q  <= led_data_d;
      led_clk_q   <= led_clk_d;
      led_latch_q <= led_latch_d;
      ready_q     <= ready_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_LEDData  = led_data_q;
  assign o_LEDClk   = led_clk_q;
  assign o_LEDLatch = led_latch_q;

endmodule : led_shift_driver
`default_nettype wire

// File: tb/tb_led_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_shift_driver
// Brief    : Scoreboard bench: a 74HC595 chain model checks every latched frame.
// Revision : 1.0
// ============================================================================
module tb_led_shift_driver;

  localparam int W = 21;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [4:0]  aux;
  logic        valid;
  logic        ready, led_data, led_clk, led_latch;

  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready, s_ldata, s_lclk, s_latch;

  always #5 clk = ~clk;

  led_shift_driver #(.WIDTH(W), .CLK_DIV(D)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_aux(aux), .i_valid(valid),
    .o_ready(ready), .o_LEDData(led_data), .o_LEDClk(led_clk), .o_LEDLatch(led_latch)
  );

  led_shift_driver #(.WIDTH(8), .CLK_DIV(1)) u_small (
    .i_clk(clk), .i_rst(rst), .i_data(s_data), .i_aux(5'd0), .i_valid(s_valid),
    .o_ready(s_ready), .o_LEDData(s_ldata), .o_LEDClk(s_lclk), .o_LEDLatch(s_latch)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected chain contents after a full frame: the frame itself, first bit deepest.
  logic [W-1:0] sb[$];
  always @(negedge clk) begin
    if (!rst && valid && ready) sb.push_back({aux, data});
  end

  logic [W-1:0] chain       = '0;
  logic [W-1:0] last_latched = '0;
  int  edges = 0, latch_len = 0, low_len = 0;
  logic prev_clk = 1'b0, prev_latch = 1'b0, prev_ready = 1'b1, prev_data = 1'b0;
  bit  skip_ready = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      edges      = 0;
      latch_len  = 0;
      low_len    = 0;
      skip_ready = 1'b1;
    end else begin
      if (led_clk && !prev_clk) begin
        chain = {chain[W-2:0], led_data};
        edges++;
      end
      if (led_clk && prev_clk && (led_data !== prev_data))
        chk("data_hold", int'(led_data), int'(prev_data));
      if (led_latch) latch_len++;
      if (!led_latch && prev_latch) begin
        if (sb.size() == 0) begin
          chk("latch_unexpected", 1, 0);
        end else begin
          chk("chain", int'(chain), int'(sb.pop_front()));
          chk("clk_edges", edges, W);
          chk("latch_len", latch_len, D);
        end
        last_latched = chain;
        edges        = 0;
        latch_len    = 0;
      end
      if (!ready) low_len++;
      if (ready && !prev_ready) begin
        if (!skip_ready) chk("ready_low", low_len, 2 * D * W + D);
        low_len    = 0;
        skip_ready = 1'b0;
      end
    end
    prev_clk   = led_clk;
    prev_latch = led_latch;
    prev_ready = ready;
    prev_data  = led_data;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    cyc();
    while (!ready && n < 600) begin
      cyc();
      n++;
    end
    if (!ready) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [4:0] a);
    data  = d;
    aux   = a;
    valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, n, lowc, latc, e, hic;
    logic pr, pc;
    logic [7:0] ch;

    rst = 1'b1; data = '0; aux = '0; valid = 1'b0; s_data = '0; s_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (10) cyc();
    chk("reset_ready", int'(ready), 1);
    chk("reset_clk",   int'(led_clk), 0);
    chk("reset_latch", int'(led_latch), 0);
    chk("reset_data",  int'(led_data), 0);

    // Directed frame
    send(16'hA5C3, 5'b10110);
    wait_idle("frame_a5c3");
    cyc();
    chk("frame_a5c3", int'(last_latched), 'h16A5C3);

    // Valid held high: back-to-back frames, second sees its own data
    data = 16'hFFFF; aux = 5'd3; valid = 1'b1;
    pr = 1'b1; gap = 0; n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (!ready && pr && n == 0) data = 16'h0001;
      if (!ready && pr) n++;
      if (ready && n == 1) gap++;
      pr = ready;
    end
    valid = 1'b0;
    chk("idle_gap", gap, 1);
    wait_idle("b2b");
    cyc();
    chk("frame_0001", int'(last_latched), int'({5'd3, 16'h0001}));

    // Reset in the middle of a frame
    send(16'h1234, 5'h1F);
    n = 0;
    while (edges < 10 && n < 400) begin
      cyc();
      n++;
    end
    chk("reach_bit10", int'(edges >= 10), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_clk",   int'(led_clk), 0);
    chk("abort_latch", int'(led_latch), 0);
    chk("abort_data",  int'(led_data), 0);
    repeat (200) cyc();
    send(16'hBEEF, 5'h0A);
    wait_idle("after_abort");
    cyc();
    chk("frame_beef", int'(last_latched), int'({5'h0A, 16'hBEEF}));

    // Random frames with inputs churning while busy
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 5)) cyc();
      send(16'($urandom), 5'($urandom));
      n = 0;
      while (!ready && n < 600) begin
        data  = 16'($urandom);
        aux   = 5'($urandom);
        valid = 1'($urandom);
        cyc();
        n++;
      end
      valid = 1'b0;
      chk("rand_done", int'(ready), 1);
    end
    wait_idle("final");
    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);

    // WIDTH=8, CLK_DIV=1 instance
    s_data  = 16'h0081;
    s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    lowc = 0; latc = 0; e = 0; hic = 0; pc = 1'b0; ch = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!s_ready) lowc++;
      if (s_latch) latc++;
      if (s_lclk) hic++;
      if (s_lclk && !pc) begin
        ch = {ch[6:0], s_ldata};
        e++;
      end
      pc = s_lclk;
    end
    chk("small_ready_low", lowc, 17);
    chk("small_latch_len", latc, 1);
    chk("small_edges", e, 8);
    chk("small_clk_high", hic, 8);
    chk("small_chain", int'(ch), 'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_led_shift_driver
`default_nettype wire
